// File: rtl/vec_eac_gen.sv
// Vector effective-address generator: expands one vector load/store into one
// row address per 8-lane chunk, writes them into an LSQ entry, then signals done.
module vec_eac_gen #(
  parameter int ADDR_W = 8,
  parameter int CHUNKS = 4,
  parameter int LSQ_W  = 4,
  parameter int RS_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [6:0]                req_opcode,
  input  logic [ADDR_W-1:0]         req_base,
  input  logic [ADDR_W-1:0]         req_stride,
  input  logic [LSQ_W-1:0]          req_lsq_idx,
  input  logic [RS_W-1:0]           req_rs_idx,
  output logic                      lsq_wr_en,
  input  logic                      lsq_wr_ready,
  output logic [LSQ_W-1:0]          lsq_wr_idx,
  output logic [$clog2(CHUNKS)-1:0] lsq_wr_chunk,
  output logic [ADDR_W-1:0]         lsq_wr_addr,
  output logic                      eac_done,
  output logic [RS_W-1:0]           eac_done_rs_idx,
  output logic                      eac_done_is_load,
  output logic                      err_illegal,
  output logic                      busy
);

  localparam int CW = $clog2(CHUNKS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GEN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [6:0] OP_VLOAD  = 7'b0000111;
  localparam logic [6:0] OP_VSTORE = 7'b0100111;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     chunk_q, chunk_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [LSQ_W-1:0]  lsq_idx_q, lsq_idx_d;
  logic [RS_W-1:0]   rs_idx_q, rs_idx_d;
  logic              is_load_q, is_load_d;
  logic              req_ready_q, req_ready_d;
  logic              wr_en_q, wr_en_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              hs;
  logic              legal;

  // The ready flop can only rise on an edge with rst low; the gate keeps the
  // port low for the whole of any cycle in which reset is asserted.
  assign req_ready = req_ready_q & ~rst;
  assign hs        = req_valid & req_ready;
  assign legal     = (req_opcode == OP_VLOAD) || (req_opcode == OP_VSTORE);

  always_comb begin
    state_d    = state_q;
    chunk_d    = chunk_q;
    cur_addr_d = cur_addr_q;
    stride_d   = stride_q;
    lsq_idx_d  = lsq_idx_q;
    rs_idx_d   = rs_idx_q;
    is_load_d  = is_load_q;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hs) begin
          if (legal) begin
            stride_d   = req_stride;
            lsq_idx_d  = req_lsq_idx;
            rs_idx_d   = req_rs_idx;
            is_load_d  = (req_opcode == OP_VLOAD);
            chunk_d    = '0;
            cur_addr_d = req_base;
            state_d    = S_GEN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_GEN: begin
        if (wr_en_q && lsq_wr_ready) begin
          if (chunk_q == CW'(CHUNKS - 1)) begin
            state_d = S_DONE;
          end else begin
            chunk_d    = chunk_q + CW'(1);
            // Negative strides fall out of modular addition; wrap is silent.
            cur_addr_d = cur_addr_q + stride_q;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Output flops are loaded from the next state so every port is registered.
    wr_en_d     = (state_d == S_GEN);
    done_d      = (state_d == S_DONE);
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      chunk_q     <= '0;
      cur_addr_q  <= '0;
      stride_q    <= '0;
      lsq_idx_q   <= '0;
      rs_idx_q    <= '0;
      is_load_q   <= 1'b0;
      req_ready_q <= 1'b0;
      wr_en_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      chunk_q     <= chunk_d;
      cur_addr_q  <= cur_addr_d;
      stride_q    <= stride_d;
      lsq_idx_q   <= lsq_idx_d;
      rs_idx_q    <= rs_idx_d;
      is_load_q   <= is_load_d;
      req_ready_q <= req_ready_d;
      wr_en_q     <= wr_en_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign lsq_wr_en        = wr_en_q;
  assign lsq_wr_idx       = lsq_idx_q;
  assign lsq_wr_chunk     = chunk_q;
  assign lsq_wr_addr      = cur_addr_q;
  assign eac_done         = done_q;
  assign eac_done_rs_idx  = rs_idx_q;
  assign eac_done_is_load = is_load_q;
  assign err_illegal      = err_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_vec_eac_gen.sv
// Bench for vec_eac_gen: directed vector table, stall and reset sequences,
// then random requests checked against an arithmetic address model.
module tb_vec_eac_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_opcode;
  logic [7:0] req_base;
  logic [7:0] req_stride;
  logic [3:0] req_lsq_idx;
  logic [2:0] req_rs_idx;
  logic       lsq_wr_en;
  logic       lsq_wr_ready;
  logic [3:0] lsq_wr_idx;
  logic [1:0] lsq_wr_chunk;
  logic [7:0] lsq_wr_addr;
  logic       eac_done;
  logic [2:0] eac_done_rs_idx;
  logic       eac_done_is_load;
  logic       err_illegal;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vec_eac_gen dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_base(req_base), .req_stride(req_stride),
    .req_lsq_idx(req_lsq_idx), .req_rs_idx(req_rs_idx),
    .lsq_wr_en(lsq_wr_en), .lsq_wr_ready(lsq_wr_ready),
    .lsq_wr_idx(lsq_wr_idx), .lsq_wr_chunk(lsq_wr_chunk), .lsq_wr_addr(lsq_wr_addr),
    .eac_done(eac_done), .eac_done_rs_idx(eac_done_rs_idx),
    .eac_done_is_load(eac_done_is_load), .err_illegal(err_illegal), .busy(busy)
  );

  typedef struct {
    logic [6:0]      op;
    logic [7:0]      base;
    logic [7:0]      stride;
    logic [3:0]      lsq;
    logic [2:0]      rs;
    logic [3:0][7:0] exp;
    bit              illegal;
    int              stall_at;
    int              stall_len;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Issues one request and follows it to completion, checking every cycle.
  task automatic do_txn(input logic [6:0] op, input logic [7:0] base, input logic [7:0] stride,
                        input logic [3:0] lsq, input logic [2:0] rs, input logic [3:0][7:0] exp,
                        input bit illegal, input bit rnd_stall, input int stall_at,
                        input int stall_len);
    int n, k, stalls, cur_stall, w;
    bit rdy;
    w = 0;
    while (!req_ready && w < 8) begin
      tick();
      w++;
    end
    chk("wait_ready", req_ready, 1);
    req_valid = 1; req_opcode = op; req_base = base; req_stride = stride;
    req_lsq_idx = lsq; req_rs_idx = rs; lsq_wr_ready = 1;
    tick();
    req_valid = 0;
    n = 1;
    if (illegal) begin
      chk("ill_err", err_illegal, 1);
      chk("ill_wr_en", lsq_wr_en, 0);
      chk("ill_done", eac_done, 0);
      chk("ill_ready", req_ready, 1);
      chk("ill_busy", busy, 0);
      tick();
      chk("ill_err_clear", err_illegal, 0);
      chk("ill_wr_en2", lsq_wr_en, 0);
      return;
    end
    k = 0; stalls = 0; cur_stall = 0;
    while (k < 4 && n < 200) begin
      chk("wr_en", lsq_wr_en, 1);
      chk("wr_idx", lsq_wr_idx, lsq);
      chk("wr_chunk", lsq_wr_chunk, k);
      chk("wr_addr", lsq_wr_addr, exp[k]);
      chk("gen_busy", busy, 1);
      chk("gen_ready", req_ready, 0);
      if (k == stall_at && cur_stall < stall_len) begin
        rdy = 0;
        cur_stall++;
      end else if (rnd_stall) begin
        rdy = ($urandom_range(0, 2) != 0);
      end else begin
        rdy = 1;
      end
      lsq_wr_ready = rdy;
      if (rdy) k++;
      else stalls++;
      tick();
      n++;
    end
    lsq_wr_ready = 1;
    if (k < 4) begin
      chk("timeout", 0, 1);
      return;
    end
    chk("done", eac_done, 1);
    chk("done_latency", n, 5 + stalls);
    chk("done_rs", eac_done_rs_idx, rs);
    chk("done_is_load", eac_done_is_load, (op == 7'b0000111));
    chk("done_wr_en", lsq_wr_en, 0);
    chk("done_ready", req_ready, 0);
    tick();
    chk("post_done", eac_done, 0);
    chk("post_ready", req_ready, 1);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    logic [3:0][7:0] mexp;
    logic [6:0] op;
    logic [7:0] b, s;
    bit ill;

    tbl[0] = '{7'b0000111, 8'h10, 8'h04, 4'd3, 3'd5, {8'h1C, 8'h18, 8'h14, 8'h10}, 0, -1, 0};
    tbl[1] = '{7'b0100111, 8'hFE, 8'h01, 4'd1, 3'd2, {8'h01, 8'h00, 8'hFF, 8'hFE}, 0, -1, 0};
    tbl[2] = '{7'b0000111, 8'h02, 8'hFF, 4'd7, 3'd6, {8'hFF, 8'h00, 8'h01, 8'h02}, 0, -1, 0};
    tbl[3] = '{7'b0110011, 8'h33, 8'h01, 4'd2, 3'd1, '0, 1, -1, 0};
    tbl[4] = '{7'b0100111, 8'h55, 8'h00, 4'hF, 3'd7, {8'h55, 8'h55, 8'h55, 8'h55}, 0, -1, 0};
    tbl[5] = '{7'b0000111, 8'h20, 8'h08, 4'd9, 3'd4, {8'h38, 8'h30, 8'h28, 8'h20}, 0, 1, 3};

    // Reset, with a legal request waiting that must not be taken.
    rst = 1; req_valid = 1; req_opcode = 7'b0000111; req_base = 8'hAA; req_stride = 8'h01;
    req_lsq_idx = 4'd1; req_rs_idx = 3'd1; lsq_wr_ready = 1;
    tick();
    tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_wr_en", lsq_wr_en, 0);
    chk("rst_done", eac_done, 0);
    chk("rst_err", err_illegal, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", lsq_wr_addr, 0);
    chk("rst_chunk", lsq_wr_chunk, 0);
    chk("rst_idx", lsq_wr_idx, 0);
    chk("rst_done_rs", eac_done_rs_idx, 0);
    req_valid = 0;
    rst = 0;

    for (int i = 0; i < 6; i++)
      do_txn(tbl[i].op, tbl[i].base, tbl[i].stride, tbl[i].lsq, tbl[i].rs, tbl[i].exp,
             tbl[i].illegal, 0, tbl[i].stall_at, tbl[i].stall_len);

    // Reset while chunk 2 is on the bus, then a fresh request from chunk 0.
    while (!req_ready) tick();
    req_valid = 1; req_opcode = 7'b0000111; req_base = 8'h40; req_stride = 8'h10;
    req_lsq_idx = 4'd6; req_rs_idx = 3'd3; lsq_wr_ready = 1;
    tick();
    req_valid = 0;
    tick();
    tick();
    chk("mid_chunk2", lsq_wr_chunk, 2);
    chk("mid_addr2", lsq_wr_addr, 8'h60);
    rst = 1;
    tick();
    chk("mid_rst_wr_en", lsq_wr_en, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", lsq_wr_addr, 0);
    chk("mid_rst_chunk", lsq_wr_chunk, 0);
    chk("mid_rst_idx", lsq_wr_idx, 0);
    chk("mid_rst_done", eac_done, 0);
    chk("mid_rst_err", err_illegal, 0);
    rst = 0;
    tick();
    chk("mid_rst_no_done", eac_done, 0);
    do_txn(tbl[0].op, tbl[0].base, tbl[0].stride, tbl[0].lsq, tbl[0].rs, tbl[0].exp, 0, 0, -1, 0);

    // Random requests against the model: chunk k address = base + k*stride mod 256.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: op = 7'b0000111;
        1: op = 7'b0100111;
        2: op = 7'b0000111;
        default: op = 7'($urandom);
      endcase
      ill = !(op == 7'b0000111 || op == 7'b0100111);
      b = 8'($urandom);
      s = 8'($urandom);
      for (int c = 0; c < 4; c++)
        mexp[c] = 8'((int'(b) + c * int'($signed(s))) % 256 + 256);
      do_txn(op, b, s, 4'($urandom), 3'($urandom), mexp, ill, 1, -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_eac_gen.md
Name: vec_eac_gen

Overview:
- Vector effective-address generator; sits directly upstream of the vector memory-access (M1–M4) stage.
- Takes one vector load/store from the vector reservation station and computes one 8-bit data-memory row address per 8-lane chunk.
- Writes those addresses into the chunk-indexed LSQ entry that M4 later reads, then signals completion so the RS entry can advance to M1.
- One request in flight at a time.

Parameters:
ADDR_W, 8, width of a data-memory row address (LSQ chunk field width)
CHUNKS, 4, chunks per vector (vector length = CHUNKS x lane_size)
LSQ_W, 4, LSQ index width
RS_W, 3, reservation-station index width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  RS presents a vector memory op
req_ready  output  1  block can accept a request this cycle
req_opcode  input  7  7'b0000111 = vector load, 7'b0100111 = vector store
req_base  input  ADDR_W  base row address
req_stride  input  ADDR_W  signed two's-complement row stride between chunks
req_lsq_idx  input  LSQ_W  LSQ entry to fill
req_rs_idx  input  RS_W  originating RS entry
lsq_wr_en  output  1  chunk address write valid
lsq_wr_ready  input  1  LSQ accepts write (0 = stall)
lsq_wr_idx  output  LSQ_W  LSQ entry being written
lsq_wr_chunk  output  $clog2(CHUNKS)  chunk index; LSQ bit slice [chunk*8+7 -: 8]
lsq_wr_addr  output  ADDR_W  row address for this chunk
eac_done  output  1  one-cycle pulse, all chunks written
eac_done_rs_idx  output  RS_W  RS entry that completed (valid with eac_done)
eac_done_is_load  output  1  1 = load, 0 = store (valid with eac_done)
err_illegal  output  1  one-cycle pulse, illegal opcode request was dropped
busy  output  1  request in flight (state != IDLE)

Behaviour:
- All outputs are registered.
- Reset values: req_ready=0 during any cycle rst=1. All other outputs are 0, chunk counter is 0, state is IDLE.
- req_ready=1 only in IDLE with rst=0.
- States: IDLE, GEN, DONE.
- IDLE:
  - Handshake is req_valid && req_ready.
  - Legal opcode: latch base, stride, lsq_idx, rs_idx, is_load. Set chunk=0, cur_addr=req_base. Go to GEN.
  - Illegal opcode: request is consumed. err_illegal=1 next cycle. No LSQ write, no eac_done, stay IDLE.
- GEN:
  - lsq_wr_en=1; lsq_wr_idx=latched idx; lsq_wr_chunk=chunk; lsq_wr_addr=cur_addr.
  - Write accepted on a cycle with lsq_wr_en && lsq_wr_ready.
  - On accept with chunk<CHUNKS-1: chunk+1; cur_addr = cur_addr + stride, mod 2^ADDR_W.
  - On accept with chunk==CHUNKS-1: go to DONE, lsq_wr_en=0.
  - lsq_wr_ready=0: hold all write outputs stable. Indefinite stall allowed.
- DONE:
  - eac_done=1 for exactly one cycle with rs_idx and is_load.
  - Next state IDLE.
  - req_ready=0 during DONE.
- Latency with lsq_wr_ready held 1:
  - Request accepted at edge T.
  - Chunk 0 presented in cycle T+1; chunk k in T+1+k.
  - eac_done in cycle T+CHUNKS+1.
  - req_ready high again in T+CHUNKS+2.
- Arithmetic rules:
  - Stride is sign-extended implicitly by mod-2^ADDR_W addition.
  - Wrap-around at 255→0 and 0→255 is legal and silent.
  - Stride 0 writes the same address to all chunks.
- Loads and stores generate identical address sequences; only eac_done_is_load differs.
- Reset mid-operation (rst=1 in GEN or DONE):
  - Next cycle is IDLE with all outputs 0.
  - Partially written LSQ entry is abandoned; no eac_done.
- req_valid while not IDLE is ignored (req_ready=0). Requester must hold it.

Test Plan:
- Load, base=8'h10, stride=8'h04, lsq_idx=3, rs_idx=5, ready=1 -> writes (3,0,10),(3,1,14),(3,2,18),(3,3,1C) in cycles T+1..T+4. eac_done=1 with rs_idx=5, is_load=1 at T+5. req_ready=1 at T+6.
- Store, base=8'hFE, stride=8'h01 -> addrs FE,FF,00,01. eac_done_is_load=0.
- Negative stride, base=8'h02, stride=8'hFF -> addrs 02,01,00,FF.
- lsq_wr_ready=0 for 3 cycles while chunk 1 is presented -> chunk 1 outputs stable throughout. Chunk 2 appears the cycle after ready returns. eac_done delayed by 3 cycles.
- Illegal opcode 7'b0110011 -> err_illegal pulse next cycle. No lsq_wr_en, no eac_done, req_ready stays 1.
- rst=1 during chunk 2 -> next cycle all outputs 0, state IDLE. A new request then completes normally from chunk 0.
